// File: rtl/rom_if_pkg.sv
// ============================================================================
// Module   : rom_if_pkg
// Brief    : Shared limits, sizing helper and tracking-stage type for the
//            multi-port ROM read front-end.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rom_if_pkg;

  localparam int MAX_PORTS       = 4;
  localparam int MAX_ROM_LATENCY = 4;

  function automatic int port_id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int PORT_ID_W = port_id_width(MAX_PORTS);

  typedef struct packed {
    logic                 valid;
    logic [PORT_ID_W-1:0] port_id;
  } trk_stage_t;

endpackage

`default_nettype wire

// File: rtl/rom_read_interface_rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick: first requester at or after the
//            pointer, ascending with wrap-around.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
  import rom_if_pkg::*;
#(
  parameter int NUM_PORTS = 2
) (
  input  logic [NUM_PORTS-1:0]                      req_i,
  input  logic [port_id_width(NUM_PORTS)-1:0]       ptr_i,
  output logic [NUM_PORTS-1:0]                      gnt_o,
  output logic [port_id_width(NUM_PORTS)-1:0]       gnt_idx_o,
  output logic                                      gnt_valid_o
);

  localparam int IDX_W = port_id_width(NUM_PORTS);

  int w_dist;
  int w_best_dist;

  // Winner is the requester with the smallest forward distance from ptr_i.
  always_comb begin
    w_dist      = 0;
    w_best_dist = NUM_PORTS;
    gnt_idx_o   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (req_i[i]) begin
        w_dist = (i >= int'(ptr_i)) ? (i - int'(ptr_i)) : (i + NUM_PORTS - int'(ptr_i));
        if (w_dist < w_best_dist) begin
          w_best_dist = w_dist;
          gnt_idx_o   = IDX_W'(i);
        end
      end
    end
    gnt_valid_o = (w_best_dist < NUM_PORTS);
  end

  generate
    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_gnt
      assign gnt_o[g] = gnt_valid_o && (gnt_idx_o == IDX_W'(g));
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/rom_read_interface.sv
// ============================================================================
// Module   : rom_read_interface
// Brief    : Round-robin multi-port read front-end for a synchronous ROM,
//            returning data with a per-port valid after ROM_LATENCY cycles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rom_read_interface
  import rom_if_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_PORTS   = 2,
  parameter int ROM_LATENCY = 1
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] port_addr_i,
  input  logic [NUM_PORTS-1:0]            port_read_req_i,
  output logic [NUM_PORTS-1:0]            port_read_ready_o,
  output logic [DATA_WIDTH-1:0]           read_data_o,
  output logic [NUM_PORTS-1:0]            port_read_data_valid_o,
  output logic [ADDR_WIDTH-1:0]           rom_addr_o,
  input  logic [DATA_WIDTH-1:0]           rom_q_i
);

  localparam int IDX_W = port_id_width(NUM_PORTS);

  logic [IDX_W-1:0] rr_ptr_q;
  logic [IDX_W-1:0] rr_ptr_d;
  logic [IDX_W-1:0] w_gnt_idx;
  logic [IDX_W-1:0] w_addr_sel;
  logic             w_accept;
  trk_stage_t       w_stage0;
  trk_stage_t       trk_q [ROM_LATENCY];

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS)
  ) u_arb (
    .req_i       (port_read_req_i),
    .ptr_i       (rr_ptr_q),
    .gnt_o       (port_read_ready_o),
    .gnt_idx_o   (w_gnt_idx),
    .gnt_valid_o (w_accept)
  );

  // Idle cycles still present a deterministic address: the pointed-to port.
  assign w_addr_sel = w_accept ? w_gnt_idx : rr_ptr_q;

  always_comb begin
    rom_addr_o = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (w_addr_sel == IDX_W'(i)) begin
        rom_addr_o = port_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (w_accept) begin
      rr_ptr_d = (w_gnt_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : w_gnt_idx + 1'b1;
    end
  end

  assign w_stage0.valid   = w_accept;
  assign w_stage0.port_id = PORT_ID_W'(w_gnt_idx);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_ptr_q <= '0;
      for (int k = 0; k < ROM_LATENCY; k++) begin
        trk_q[k] <= '0;
      end
    end else begin
      rr_ptr_q <= rr_ptr_d;
      trk_q[0] <= w_stage0;
      for (int k = 1; k < ROM_LATENCY; k++) begin
        trk_q[k] <= trk_q[k-1];
      end
    end
  end

  generate
    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_valid
      assign port_read_data_valid_o[g] = trk_q[ROM_LATENCY-1].valid &&
                                         (trk_q[ROM_LATENCY-1].port_id == PORT_ID_W'(g));
    end
  endgenerate

  assign read_data_o = rom_q_i;

endmodule

`default_nettype wire

// File: tb/tb_rom_read_interface.sv
// ============================================================================
// Module   : tb_rom_read_interface
// Brief    : Randomised scoreboard bench with a ROM model and a behavioural
//            round-robin reference for rom_read_interface.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rom_read_interface;

  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int NP  = 3;
  localparam int LAT = 2;

  typedef struct {
    int          port;
    logic [DW-1:0] data;
    int          due;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [NP*AW-1:0] port_addr;
  logic [NP-1:0]    req;
  logic [NP-1:0]    ready;
  logic [NP-1:0]    vld;
  logic [DW-1:0]    rdata;
  logic [DW-1:0]    rom_q;
  logic [AW-1:0]    rom_addr;
  logic [AW-1:0]    ap [LAT];

  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;
  int   m_ptr    = 0;
  exp_t sb [$];

  always #5 clk = ~clk;

  rom_read_interface #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .NUM_PORTS   (NP),
    .ROM_LATENCY (LAT)
  ) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .port_addr_i            (port_addr),
    .port_read_req_i        (req),
    .port_read_ready_o      (ready),
    .read_data_o            (rdata),
    .port_read_data_valid_o (vld),
    .rom_addr_o             (rom_addr),
    .rom_q_i                (rom_q)
  );

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return (DW'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // Synchronous ROM with LAT cycles from address to data.
  always @(posedge clk) begin
    ap[0] <= rom_addr;
    for (int k = 1; k < LAT; k++) ap[k] <= ap[k-1];
  end
  assign rom_q = rom_word(ap[LAT-1]);

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input bit ok,
                                input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endfunction

  function automatic int winner(input logic [NP-1:0] r, input int ptr);
    for (int k = 0; k < NP; k++) begin
      if (r[(ptr + k) % NP]) return (ptr + k) % NP;
    end
    return -1;
  endfunction

  function automatic logic [AW-1:0] addr_of(input int p);
    logic [NP*AW-1:0] v;
    v = port_addr;
    return v[p*AW +: AW];
  endfunction

  // Monitor: every returned strobe must match the oldest outstanding read.
  always @(negedge clk) begin
    if (mon_en) begin
      while (sb.size() > 0 && sb[0].due < cyc) begin
        check("missing_return", 1'b0, 64'(vld), 64'(sb[0].port));
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
        check("valid_port", vld === NP'(1 << sb[0].port), 64'(vld), 64'(1 << sb[0].port));
        check("read_data", rdata === sb[0].data, 64'(rdata), 64'(sb[0].data));
        void'(sb.pop_front());
      end else begin
        check("valid_idle", vld === '0, 64'(vld), 64'(0));
      end
    end
  end

  initial begin
    int   w;
    int   thr;
    int   phase;
    exp_t e;
    reset_n   = 1'b0;
    req       = '0;
    port_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b1;

    for (int t = 0; t < 3000; t++) begin
      @(posedge clk);
      #1;
      phase = (t / 200) % 5;
      case (phase)
        0: thr = 15;
        1: thr = 50;
        2: thr = 85;
        default: thr = 100;
      endcase
      if ($urandom_range(0, 99) < 2) begin
        reset_n = 1'b0;
        // Reads still in flight at the reset edge never return.
        while (sb.size() > 0 && sb[$].due > cyc) void'(sb.pop_back());
      end else begin
        reset_n = 1'b1;
      end
      for (int p = 0; p < NP; p++) begin
        req[p] = ($urandom_range(0, 99) < thr);
        port_addr[p*AW +: AW] = (phase == 4) ? AW'(p + 1) : AW'($urandom);
      end
      if (phase == 3 && ((t / 20) % 2 == 1)) req = NP'(1 << ((t / 40) % NP));

      @(negedge clk);
      w = winner(req, m_ptr);
      check("ready", ready === ((w < 0) ? NP'(0) : NP'(1 << w)), 64'(ready),
            64'((w < 0) ? 0 : (1 << w)));
      check("rom_addr", rom_addr === addr_of((w < 0) ? m_ptr : w), 64'(rom_addr),
            64'(addr_of((w < 0) ? m_ptr : w)));
      if (!reset_n) begin
        m_ptr = 0;
      end else if (w >= 0) begin
        e.port = w;
        e.data = rom_word(addr_of(w));
        e.due  = cyc + LAT;
        sb.push_back(e);
        m_ptr = (w + 1) % NP;
      end
    end

    @(posedge clk);
    #1;
    reset_n = 1'b1;
    req     = '0;
    repeat (LAT + 3) @(negedge clk);
    check("drain_empty", sb.size() == 0, 64'(sb.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
